cortex_m0_ahb_sram: RTL and testbench
=====================================

// Module: cortex_m0_ahb_sram
// PURPOSE
//   AHB-Lite subordinate (responder) fronting a single-port synchronous SRAM. The cortex_m0_core bus interface
//   is the manager. Accepts single transfers only: HBURST/HPROT are not connected.
//   Features: byte/halfword/word lanes, one-entry posted write buffer with read forwarding,
//   programmable wait states, two-cycle ERROR response. Instruction and data fetch share this path.
// PARAMETERS
//   ADDR_W       12  byte-address bits decoded (memory = 2**(ADDR_W-2) 32-bit words)
//   WAIT_STATES  0   hreadyout-low cycles inserted in every OKAY data phase (0..15)
// PORTS
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   hsel       in   1   responder select
//   haddr      in   32  byte address; bits [31:ADDR_W] ignored, so the memory aliases
//   htrans     in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   hwrite     in   1   1=write 0=read
//   hsize      in   3   0=byte 1=half 2=word; >2 is illegal
//   hwdata     in   32  write data, valid in the data phase
//   hready     in   1   bus-level ready; an address phase is sampled only when this is 1
//   hrdata     out  32  read data, valid when hreadyout=1 in a read data phase
//   hreadyout  out  1   0 = extend the current data phase
//   hresp      out  1   0=OKAY 1=ERROR
// BEHAVIOUR
//   Reset values: hreadyout=1, hresp=0, hrdata=0.
//   Reset clears the state to IDLE and discards the write buffer. SRAM contents are not cleared.
//   Accept condition: hsel & htrans[1] & hready. IDLE/BUSY or hsel=0 -> zero-wait OKAY, no access.
//   Legality: hsize>2, half with haddr[0]=1, or word with haddr[1:0]!=0 -> ERROR. No memory side effect.
//   Byte lanes (little-endian):
//     - byte: lane haddr[1:0]
//     - half: lanes {haddr[1],0} and {haddr[1],1}
//     - word: all four lanes
//   FSM states: IDLE, DATA, WAIT, ERR1, ERR2.
//     IDLE --legal accept--> WAIT when WAIT_STATES>0, else DATA.
//     IDLE --illegal accept--> ERR1.
//     WAIT: hreadyout=0, counter loaded with WAIT_STATES-1, decremented each cycle -> DATA at 0.
//     DATA: hreadyout=1, hresp=0. A new accept in DATA follows the same rules as from IDLE.
//       With no new accept, DATA -> IDLE.
//     ERR1: hreadyout=0, hresp=1 -> ERR2.
//     ERR2: hreadyout=1, hresp=1. An accept here is decoded normally, same as from IDLE.
//   Reads:
//     - SRAM read is launched at the accepting edge, so data appears in the first data-phase cycle.
//     - hrdata holds its value through wait states.
//     - Full word is always returned; lane selection is the manager's job.
//   Writes (posted):
//     - At the end of the write data phase (hreadyout=1), hwdata, the lane mask and the word
//       address are captured into the write buffer.
//     - The buffer drains into the SRAM on the next cycle in which no read is launched.
//     - A further write accept while the buffer is full forces a drain first.
//     - Single-port SRAM: one read or one write per cycle. A read launch takes priority
//       over the drain, and the buffer holds.
//   Forwarding:
//     - A read whose word address matches a valid buffer entry returns the SRAM word
//       with the buffered lanes substituted.
//     - This includes a read accepted in the same cycle as the write data phase completes:
//       hwdata is forwarded directly.
//   Wrap: word index = haddr[ADDR_W-1:2]. Addresses ≥ 2**ADDR_W alias modulo size, with no error.
//   Reset mid-transfer: outputs return to reset values asynchronously. An in-flight or buffered
//   write is lost, with no partial lane update.
//   Latency: read OKAY = 1+WAIT_STATES cycles of data phase. Write = same; the SRAM update is off the critical path.
// TESTING
//   1 WAIT_STATES=0: word write 0x100=0xDEADBEEF, then read 0x100 -> hrdata=0xDEADBEEF, hreadyout never low, hresp=0.
//   2 After 1: byte write 0xA5 to 0x101, then a back-to-back read of 0x100 on the next cycle -> 0xDEADA5EF.
//     This is forwarded from the buffer. A later read (after drain) also gives 0xDEADA5EF.
//   3 Half write to 0x103 -> hreadyout=0,hresp=1 then hreadyout=1,hresp=1. A read of 0x100 still gives 0xDEADA5EF.
//   4 WAIT_STATES=2: read 0x100 -> hreadyout low exactly 2 cycles, then 1 with correct data.
//     hsize=3 access -> ERROR with no wait states.
//   5 ADDR_W=12: write 0x1004=0x12345678, read 0x0004 -> 0x12345678. An htrans=BUSY cycle gives OKAY with zero wait.
//   6 Assert reset during WAIT with a write buffered -> hreadyout=1, hresp=0, hrdata=0 immediately.
//     The buffered word is not written.

Source files
------------

// File: rtl/cortex_m0_ahb_sram.sv
// AHB-Lite responder in front of a single-port synchronous SRAM: byte/half/word lanes,
// one-entry posted write buffer with read forwarding, programmable wait states.
module cortex_m0_ahb_sram #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);
    localparam int unsigned IdxW   = ADDR_W - 2;
    localparam int unsigned Words  = 2 ** IdxW;
    localparam logic [3:0]  WsLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {StIdle, StData, StWait, StErr1, StErr2} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              dp_write_q;
    logic [IdxW-1:0]   dp_idx_q;
    logic [3:0]        dp_mask_q;
    logic              wb_valid_q;
    logic [IdxW-1:0]   wb_idx_q;
    logic [3:0]        wb_mask_q;
    logic [31:0]       wb_data_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [Words];

    logic              can_accept, accept, legal, acc_ok, acc_err;
    logic              rd_launch, wr_accept, wr_done, wb_hit, dp_hit;
    logic [3:0]        lane_mask;
    logic [IdxW-1:0]   a_idx;
    logic [31:0]       rd_word;
    logic              ram_we;
    logic [IdxW-1:0]   ram_idx;
    logic [3:0]        ram_mask;
    logic [31:0]       ram_data;
    logic              unused_bits;

    assign unused_bits = ^{haddr[31:ADDR_W], htrans[0]};
    assign a_idx       = haddr[ADDR_W-1:2];
    assign hrdata      = rdata_q;

    always_comb begin
        legal     = 1'b1;
        lane_mask = 4'b1111;
        case (hsize)
            3'd0: lane_mask = 4'b0001 << haddr[1:0];
            3'd1: begin
                legal     = ~haddr[0];
                lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2:    legal = (haddr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign accept     = can_accept & hsel & htrans[1] & hready;
    assign acc_ok     = accept & legal;
    assign acc_err    = accept & ~legal;
    assign rd_launch  = acc_ok & ~hwrite;
    assign wr_accept  = acc_ok & hwrite;
    assign wr_done    = (state_q == StData) & dp_write_q;
    assign wb_hit     = wb_valid_q && (wb_idx_q == a_idx);
    assign dp_hit     = wr_done && (dp_idx_q == a_idx);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StWait: begin
                if (cnt_q == 4'd0) state_d = StData;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StErr1: state_d = StErr2;
            default: begin
                state_d = StIdle;
                if (acc_err) begin
                    state_d = StErr1;
                end else if (acc_ok) begin
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WsLoad;
                    end else begin
                        state_d = StData;
                    end
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state_q)
            StWait: hreadyout = 1'b0;
            StErr1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            StErr2:  hresp = 1'b1;
            default: ;
        endcase
    end

    // Youngest data wins: completing write over buffer entry over SRAM word.
    always_comb begin
        rd_word = mem[a_idx];
        for (int i = 0; i < 4; i++) begin
            if (wb_hit && wb_mask_q[i]) rd_word[8*i +: 8] = wb_data_q[8*i +: 8];
            if (dp_hit && dp_mask_q[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
        end
    end

    // Port arbitration: a read launch owns the SRAM; otherwise drain the buffer, and a
    // completing write with an empty buffer goes straight to the array.
    always_comb begin
        ram_we   = 1'b0;
        ram_idx  = wb_idx_q;
        ram_mask = wb_mask_q;
        ram_data = wb_data_q;
        if (!rd_launch) begin
            if (wb_valid_q) begin
                ram_we = 1'b1;
            end else if (wr_done) begin
                ram_we   = 1'b1;
                ram_idx  = dp_idx_q;
                ram_mask = dp_mask_q;
                ram_data = hwdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_write_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_mask_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_mask_q  <= '0;
            wb_data_q  <= '0;
            rdata_q    <= '0;
        end else begin
            if (can_accept) begin
                dp_write_q <= wr_accept;
                dp_idx_q   <= a_idx;
                dp_mask_q  <= lane_mask;
            end
            if (wr_done && (rd_launch || wb_valid_q)) begin
                wb_valid_q <= 1'b1;
                wb_idx_q   <= dp_idx_q;
                wb_mask_q  <= dp_mask_q;
                wb_data_q  <= hwdata;
            end else if (!rd_launch && wb_valid_q) begin
                wb_valid_q <= 1'b0;
            end
            if (rd_launch) rdata_q <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_mask[i]) mem[ram_idx][8*i +: 8] <= ram_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_cortex_m0_ahb_sram.sv
// Directed bench for cortex_m0_ahb_sram: two instances (0 and 2 wait states), pipelined
// AHB driver, expected responses queued at address phase and checked at data-phase end.
module tb_cortex_m0_ahb_sram;

    typedef struct {
        int          id;
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] exp;
    } tr_t;

    typedef struct {
        int          id;
        bit          is_read;
        bit          err;
        logic [31:0] data;
        int          waits;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset [2];
    logic        hsel [2];
    logic [31:0] haddr [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hreadyout [2];
    logic        hresp [2];

    int  ws [2] = '{0, 2};
    int  n_cmp = 0;
    int  n_bad = 0;
    tr_t seq_q [$];
    sb_t sb_q [$];

    always #5 clk = ~clk;

    cortex_m0_ahb_sram #(.ADDR_W(12), .WAIT_STATES(0)) u_dut0 (
        .clk      (clk),
        .reset    (reset[0]),
        .hsel     (hsel[0]),
        .haddr    (haddr[0]),
        .htrans   (htrans[0]),
        .hwrite   (hwrite[0]),
        .hsize    (hsize[0]),
        .hwdata   (hwdata[0]),
        .hready   (hreadyout[0]),
        .hrdata   (hrdata[0]),
        .hreadyout(hreadyout[0]),
        .hresp    (hresp[0])
    );

    cortex_m0_ahb_sram #(.ADDR_W(12), .WAIT_STATES(2)) u_dut1 (
        .clk      (clk),
        .reset    (reset[1]),
        .hsel     (hsel[1]),
        .haddr    (haddr[1]),
        .htrans   (htrans[1]),
        .hwrite   (hwrite[1]),
        .hsize    (hsize[1]),
        .hwdata   (hwdata[1]),
        .hready   (hreadyout[1]),
        .hrdata   (hrdata[1]),
        .hreadyout(hreadyout[1]),
        .hresp    (hresp[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void add(input int id, input bit wr, input logic [31:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                input bit err, input logic [31:0] exp);
        tr_t t;
        t.id = id; t.sel = 1'b1; t.trans = 2'b10; t.wr = wr; t.addr = addr;
        t.size = size; t.wdata = wdata; t.err = err; t.exp = exp;
        seq_q.push_back(t);
    endfunction

    function automatic void add_nop(input int id, input bit sel, input logic [1:0] trans);
        tr_t t;
        t.id = id; t.sel = sel; t.trans = trans; t.wr = 1'b0; t.addr = 32'h0;
        t.size = 3'd2; t.wdata = 32'h0; t.err = 1'b0; t.exp = 32'h0;
        seq_q.push_back(t);
    endfunction

    task automatic drive_addr(input int d, input bit v, input tr_t t);
        sb_t s;
        if (!v) begin
            hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
            haddr[d] = 32'h0; hsize[d] = 3'd0;
        end else begin
            hsel[d] = t.sel; htrans[d] = t.trans; hwrite[d] = t.wr;
            haddr[d] = t.addr; hsize[d] = t.size;
            s.id = t.id;
            s.is_read = t.sel && t.trans[1] && !t.wr;
            s.err = t.err;
            s.data = t.exp;
            s.waits = t.err ? 1 : ((t.sel && t.trans[1]) ? ws[d] : 0);
            sb_q.push_back(s);
        end
    endtask

    // Runs seq_q on instance d; call and return just after a rising edge.
    task automatic run(input int d);
        tr_t nxt, cur;
        bit  nxt_v, cur_v, acc;
        int  waits;
        sb_t s;
        nxt_v = 1'b0; cur_v = 1'b0; waits = 0;
        nxt = '{default: '0};
        if (seq_q.size() > 0) begin
            nxt = seq_q.pop_front();
            nxt_v = 1'b1;
        end
        drive_addr(d, nxt_v, nxt);
        for (int cyc = 0; cyc < 400 && (nxt_v || cur_v); cyc++) begin
            @(negedge clk);
            acc = hreadyout[d];
            if (cur_v) begin
                if (hreadyout[d]) begin
                    s = sb_q.pop_front();
                    check($sformatf("t%0d.waits", s.id), waits, s.waits);
                    check($sformatf("t%0d.hresp", s.id), hresp[d], s.err);
                    if (s.is_read && !s.err)
                        check($sformatf("t%0d.hrdata", s.id), hrdata[d], s.data);
                    cur_v = 1'b0;
                end else begin
                    check($sformatf("t%0d.hresp_low", sb_q[0].id), hresp[d], sb_q[0].err);
                    waits++;
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (nxt_v) begin
                    cur = nxt;
                    cur_v = 1'b1;
                    waits = 0;
                    hwdata[d] = cur.wdata;
                end
                if (seq_q.size() > 0) begin
                    nxt = seq_q.pop_front();
                    nxt_v = 1'b1;
                end else begin
                    nxt_v = 1'b0;
                end
                drive_addr(d, nxt_v, nxt);
            end
        end
        if (nxt_v || cur_v) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run%0d timeout: observed pending transfers, required none", d);
            seq_q.delete();
            sb_q.delete();
        end
    endtask

    initial begin
        bit got;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1;
            hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
            haddr[d] = 32'h0; hsize[d] = 3'd0; hwdata[d] = 32'h0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d.hreadyout", d), hreadyout[d], 1);
            check($sformatf("rst%0d.hresp", d), hresp[d], 0);
            check($sformatf("rst%0d.hrdata", d), hrdata[d], 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Zero wait states: forwarding, drain, errors, aliasing, IDLE/BUSY/unselected
        add(1, 1, 32'h100, 3'd2, 32'hDEAD_BEEF, 0, 32'h0);
        add(2, 0, 32'h100, 3'd2, 32'h0, 0, 32'hDEAD_BEEF);
        add(3, 1, 32'h101, 3'd0, 32'hA5A5_A5A5, 0, 32'h0);
        add(4, 0, 32'h100, 3'd2, 32'h0, 0, 32'hDEAD_A5EF);
        add_nop(5, 1, 2'b00);
        add_nop(6, 0, 2'b00);
        add(7, 0, 32'h100, 3'd2, 32'h0, 0, 32'hDEAD_A5EF);
        add(8, 1, 32'h103, 3'd1, 32'h7777_7777, 1, 32'h0);
        add(9, 0, 32'h100, 3'd2, 32'h0, 0, 32'hDEAD_A5EF);
        add(10, 0, 32'h100, 3'd3, 32'h0, 1, 32'h0);
        add(11, 1, 32'h1004, 3'd2, 32'h1234_5678, 0, 32'h0);
        add(12, 0, 32'h0004, 3'd2, 32'h0, 0, 32'h1234_5678);
        add_nop(13, 1, 2'b01);
        add(14, 1, 32'h006, 3'd1, 32'hCAFE_CAFE, 0, 32'h0);
        add(15, 0, 32'hFFFF_F004, 3'd2, 32'h0, 0, 32'hCAFE_5678);
        add(16, 1, 32'h004, 3'd0, 32'h1111_1111, 0, 32'h0);
        add(17, 0, 32'h004, 3'd0, 32'h0, 0, 32'hCAFE_5611);
        add_nop(18, 0, 2'b10);
        add(19, 0, 32'h004, 3'd2, 32'h0, 0, 32'hCAFE_5611);
        add(20, 1, 32'h102, 3'd2, 32'h9999_9999, 1, 32'h0);
        add(21, 0, 32'h100, 3'd2, 32'h0, 0, 32'hDEAD_A5EF);
        run(0);

        // Two wait states
        add(30, 1, 32'h100, 3'd2, 32'h0BAD_F00D, 0, 32'h0);
        add(31, 0, 32'h100, 3'd2, 32'h0, 0, 32'h0BAD_F00D);
        add(32, 0, 32'h100, 3'd3, 32'h0, 1, 32'h0);
        add(33, 0, 32'h100, 3'd2, 32'h0, 0, 32'h0BAD_F00D);
        add(34, 1, 32'h200, 3'd2, 32'hAAAA_AAAA, 0, 32'h0);
        add_nop(35, 1, 2'b00);
        add_nop(36, 1, 2'b00);
        run(1);

        // Reset during a read wait state with a write sitting in the buffer
        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1;
        haddr[1] = 32'h200; hsize[1] = 3'd2;
        @(posedge clk);
        #1;
        hwdata[1] = 32'h5555_5555; hwrite[1] = 1'b0; haddr[1] = 32'h300;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = hreadyout[1];
            @(posedge clk);
            #1;
        end
        hsel[1] = 1'b0; htrans[1] = 2'b00;
        check("t40.accepted", got, 1);
        check("t40.in_wait", hreadyout[1], 0);
        #2;
        reset[1] = 1'b1;
        #1;
        check("t40.rst_hreadyout", hreadyout[1], 1);
        check("t40.rst_hresp", hresp[1], 0);
        check("t40.rst_hrdata", hrdata[1], 32'h0);
        @(posedge clk);
        #1;
        reset[1] = 1'b0;
        add(41, 0, 32'h200, 3'd2, 32'h0, 0, 32'hAAAA_AAAA);
        run(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
